// File: rtl/render_scheduler_if.sv
// Handshake bundle between the frame scheduler and the surrounding pose, clear,
// transform and line-draw engines. The master modport is the scheduler's view.
interface render_scheduler_if #(
    parameter int VIDX_W = 4,
    parameter int EIDX_W = 4
);
    logic              frame_start;
    logic              clr_screen;
    logic [95:0]       pose_in;
    logic [95:0]       pose_out;
    logic              clr_start;
    logic              clr_done;
    logic              xf_valid;
    logic              xf_ready;
    logic [VIDX_W-1:0] xf_vidx;
    logic              xf_ack;
    logic              ln_valid;
    logic              ln_ready;
    logic [EIDX_W-1:0] ln_eidx;
    logic              ln_busy;
    logic              busy;
    logic              frame_done;
    logic              overrun;

    modport master (
        input  frame_start, clr_screen, pose_in, clr_done,
        input  xf_ready, xf_ack, ln_ready, ln_busy,
        output pose_out, clr_start, xf_valid, xf_vidx,
        output ln_valid, ln_eidx, busy, frame_done, overrun
    );

    modport slave (
        output frame_start, clr_screen, pose_in, clr_done,
        output xf_ready, xf_ack, ln_ready, ln_busy,
        input  pose_out, clr_start, xf_valid, xf_vidx,
        input  ln_valid, ln_eidx, busy, frame_done, overrun
    );
endinterface

// File: rtl/render_scheduler.sv
// Per-frame sequencer: latches the pose on frame start, optionally clears the
// framebuffer, then issues every vertex to the transform engine and every edge to the rasterizer.
module render_scheduler #(
    parameter int NUM_VERTS = 8,
    parameter int NUM_EDGES = 12,
    parameter int VIDX_W    = 4,
    parameter int EIDX_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    render_scheduler_if.master bus
);
    localparam int                ACK_W     = $clog2(NUM_VERTS + 1);
    localparam logic [VIDX_W-1:0] LAST_VIDX = VIDX_W'(NUM_VERTS - 1);
    localparam logic [EIDX_W-1:0] LAST_EIDX = EIDX_W'(NUM_EDGES - 1);
    localparam logic [ACK_W-1:0]  ALL_ACKS  = ACK_W'(NUM_VERTS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_XFORM,
        S_DRAW,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [95:0]       pose_q;
    logic              clr_start_q;
    logic              xf_valid_q;
    logic [VIDX_W-1:0] vidx_q;
    logic              ln_valid_q;
    logic [EIDX_W-1:0] eidx_q;
    logic              busy_q;
    logic              frame_done_q;
    logic              overrun_q;
    logic [ACK_W-1:0]  ack_cnt_q;
    logic              xf_issued_q;
    logic              ln_issued_q;

    logic              xf_fire;
    logic              ln_fire;
    logic [ACK_W-1:0]  ack_cnt_d;
    logic              xf_issued_d;

    // Acks and the final issue may land on the same edge, so the XFORM exit
    // decision looks at the post-edge counts rather than the registered ones.
    always_comb begin
        xf_fire     = xf_valid_q && bus.xf_ready;
        ln_fire     = ln_valid_q && bus.ln_ready;
        ack_cnt_d   = ack_cnt_q;
        if ((state_q == S_XFORM) && bus.xf_ack && (ack_cnt_q != ALL_ACKS)) begin
            ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end
        xf_issued_d = xf_issued_q || (xf_fire && (vidx_q == LAST_VIDX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pose_q       <= '0;
            clr_start_q  <= 1'b0;
            xf_valid_q   <= 1'b0;
            vidx_q       <= '0;
            ln_valid_q   <= 1'b0;
            eidx_q       <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            ack_cnt_q    <= '0;
            xf_issued_q  <= 1'b0;
            ln_issued_q  <= 1'b0;
        end else begin
            clr_start_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= (state_q != S_IDLE) && bus.frame_start;

            case (state_q)
                S_IDLE: begin
                    if (bus.frame_start) begin
                        pose_q <= bus.pose_in;
                        busy_q <= 1'b1;
                        if (bus.clr_screen) begin
                            state_q     <= S_CLEAR;
                            clr_start_q <= 1'b1;
                        end else begin
                            state_q     <= S_XFORM;
                            xf_valid_q  <= 1'b1;
                            vidx_q      <= '0;
                            ack_cnt_q   <= '0;
                            xf_issued_q <= 1'b0;
                        end
                    end
                end

                S_CLEAR: begin
                    if (bus.clr_done) begin
                        state_q     <= S_XFORM;
                        xf_valid_q  <= 1'b1;
                        vidx_q      <= '0;
                        ack_cnt_q   <= '0;
                        xf_issued_q <= 1'b0;
                    end
                end

                S_XFORM: begin
                    ack_cnt_q   <= ack_cnt_d;
                    xf_issued_q <= xf_issued_d;
                    if (xf_fire) begin
                        if (vidx_q == LAST_VIDX) begin
                            xf_valid_q <= 1'b0;
                        end else begin
                            vidx_q <= vidx_q + VIDX_W'(1);
                        end
                    end
                    if (xf_issued_d && (ack_cnt_d == ALL_ACKS)) begin
                        state_q     <= S_DRAW;
                        ln_valid_q  <= 1'b1;
                        eidx_q      <= '0;
                        ln_issued_q <= 1'b0;
                    end
                end

                S_DRAW: begin
                    // ln_busy is only trusted once the final edge has left the handshake.
                    if (ln_fire) begin
                        if (eidx_q == LAST_EIDX) begin
                            ln_valid_q  <= 1'b0;
                            ln_issued_q <= 1'b1;
                        end else begin
                            eidx_q <= eidx_q + EIDX_W'(1);
                        end
                    end else if (ln_issued_q && !bus.ln_busy) begin
                        state_q      <= S_DONE;
                        frame_done_q <= 1'b1;
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pose_out   = pose_q;
    assign bus.clr_start  = clr_start_q;
    assign bus.xf_valid   = xf_valid_q;
    assign bus.xf_vidx    = vidx_q;
    assign bus.ln_valid   = ln_valid_q;
    assign bus.ln_eidx    = eidx_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.overrun    = overrun_q;
endmodule
